// File: rtl/sram_lsu_master.sv
// LSU-side request initiator for the IS61WV25616 SRAM controller (byte/half/word, aligned, in-region).
// Defining SRAM_TIMEOUT_EN adds a WAIT-state watchdog that ends a stuck access with o_err.
module sram_lsu_master #(
  parameter logic [31:0] SRAM_BASE = 32'h0000_0000
`ifdef SRAM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [17:0] o_SRAM_ADDR,
  output logic [31:0] o_SRAM_WDATA,
  output logic [3:0]  o_SRAM_BMASK,
  output logic        o_SRAM_WREN,
  output logic        o_SRAM_RDEN,
  input  logic [31:0] i_SRAM_RDATA,
  input  logic        i_SRAM_ACK
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic        w_accept;
  logic        w_req_err;
  logic        w_timeout;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_wren_nxt;
  logic        w_rden_nxt;
  logic [31:0] w_rdata_nxt;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic [3:0]  w_bmask;
  logic [31:0] w_wdata;

  assign w_accept  = i_req && o_ready;
  assign w_req_err = (i_size == 2'b11)
                  || ((i_size == 2'b01) && i_addr[0])
                  || ((i_size == 2'b10) && (i_addr[1:0] != 2'b00))
                  || (i_addr[31:19] != SRAM_BASE[31:19]);

  // Store lane mask and replicated write data; loads read the whole word
  always_comb begin
    w_bmask = 4'b1111;
    w_wdata = i_wdata;
    if (i_we) begin
      case (i_size)
        2'b00: begin
          w_bmask = 4'b0001 << i_addr[1:0];
          w_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          w_bmask = 4'b0011 << {i_addr[1], 1'b0};
          w_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          w_bmask = 4'b1111;
          w_wdata = i_wdata;
        end
      endcase
    end
  end

  assign w_shift = i_SRAM_RDATA >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = r_unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

`ifdef SRAM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_wren_nxt  = 1'b0;
    w_rden_nxt  = 1'b0;
    w_rdata_nxt = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_wren_nxt  = i_we;
            w_rden_nxt  = !i_we;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_SRAM_ACK) begin
          w_state_nxt = S_RESP;
          w_done_nxt  = 1'b1;
          w_rdata_nxt = r_we ? 32'd0 : w_load;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= 32'd0;
      o_SRAM_WREN <= 1'b0;
      o_SRAM_RDEN <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      o_ready     <= (w_state_nxt == S_IDLE);
      o_done      <= w_done_nxt;
      o_err       <= w_err_nxt;
      o_rdata     <= w_rdata_nxt;
      o_SRAM_WREN <= w_wren_nxt;
      o_SRAM_RDEN <= w_rden_nxt;
    end
  end

  // Request fields captured at acceptance and held until the next one
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_addr_lo    <= 2'b00;
      o_SRAM_ADDR  <= 18'd0;
      o_SRAM_WDATA <= 32'd0;
      o_SRAM_BMASK <= 4'd0;
    end else if (w_accept) begin
      r_we         <= i_we;
      r_unsigned   <= i_unsigned;
      r_size       <= i_size;
      r_addr_lo    <= i_addr[1:0];
      o_SRAM_ADDR  <= {i_addr[18:2], 1'b0};
      o_SRAM_WDATA <= w_wdata;
      o_SRAM_BMASK <= w_bmask;
    end
  end

endmodule

// File: doc/sram_lsu_master.md
Name: sram_lsu_master

Overview:
- Request-side initiator for the 32-bit IS61WV25616 SRAM controller (3-cycle read latency, 2-cycle write latency).
- Takes byte/half/word load-store requests from the core LSU over a valid/ready handshake.
- Drives the controller's single-cycle WREN/RDEN request pulse, waits for ACK, then returns aligned, extended read data with a one-cycle done pulse.
- Rejects misaligned or out-of-region accesses without touching the SRAM.

Parameters:
- SRAM_BASE, 32'h0000_0000, byte base of the 512 KiB SRAM region; bits [18:0] must be 0.
- TIMEOUT_CYCLES, 15, WAIT-state cycle limit. Used only with SRAM_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- i_req  in  1  LSU request valid; held by the LSU until accepted
- o_ready  out  1  high only in IDLE; acceptance = i_req && o_ready at a rising edge
- i_we  in  1  1 = store, 0 = load
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- i_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- i_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- o_done  out  1  one-cycle response pulse
- o_err  out  1  valid with o_done: misaligned, illegal size, out of region, or timeout
- o_rdata  out  32  load result, valid with o_done; 0 for stores and errors
- o_SRAM_ADDR  out  18  halfword address to controller
- o_SRAM_WDATA  out  32  write data to controller
- o_SRAM_BMASK  out  4  byte mask to controller
- o_SRAM_WREN  out  1  write request pulse
- o_SRAM_RDEN  out  1  read request pulse
- i_SRAM_RDATA  in  32  controller read data
- i_SRAM_ACK  in  1  controller acknowledge

Behaviour:
- Reset (async, i_reset=0): state IDLE. All outputs 0 except o_ready=1. Latched request registers are cleared.
- States:
  - IDLE: on accept, latch we/addr/wdata/size/unsigned. If there is an error condition, go RESP with err=1; otherwise go ISSUE.
  - ISSUE: assert exactly one of o_SRAM_WREN/o_SRAM_RDEN for exactly one cycle, then go WAIT.
  - WAIT: when i_SRAM_ACK=1, capture formatted read data and go RESP. WREN/RDEN stay 0 throughout.
  - RESP: o_done=1 for one cycle, then go IDLE.
- Error conditions:
  - i_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:19] != SRAM_BASE[31:19].
- Latency, with acceptance at cycle C:
  - Request pulse at C+1.
  - Store done at C+4.
  - Load done at C+5.
  - Error done at C+1.
- o_SRAM_ADDR = {addr[18:2],1'b0}. Driven from the latched address and held stable from ISSUE through RESP.
- Store mask and data:
  - Byte: mask = 4'b0001<<addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011<<{addr[1],1'b0}; data = {2{wdata[15:0]}}.
  - Word: mask = 4'b1111; data = wdata.
- Loads: mask = 4'b1111. Result = i_SRAM_RDATA>>(8*addr[1:0]), truncated to the access size, then sign- or zero-extended per i_unsigned. For a word access i_unsigned is ignored.
- Stray i_SRAM_ACK outside WAIT is ignored.
- i_req while not IDLE is not accepted (o_ready=0); the LSU holds it.
- Back-to-back requests: the next acceptance is possible at the cycle after RESP. The controller is therefore always back in an idle or ack state when a new pulse arrives.
- Reset mid-transaction: immediate return to IDLE, and no o_done is produced for the aborted request.

Optional Feature:
- Macro SRAM_TIMEOUT_EN.
- When defined:
  - A 4-bit-minimum counter clears on ISSUE and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ACK, go RESP with o_err=1 and o_rdata=0.
  - A later stray ACK is ignored.
- When undefined: WAIT persists indefinitely until ACK, and no counter logic exists.

Test Plan:
- Store word, addr 0x0000_0010, wdata 0xDEADBEEF -> at C+1: WREN=1, SRAM_ADDR=0x00008, BMASK=1111, WDATA=0xDEADBEEF. Then o_done=1 at C+4 with err=0 and rdata=0.
- Store half, addr 0x12, wdata 0x0000_ABCD -> SRAM_ADDR=0x00008, BMASK=1100, WDATA=0xABCD_ABCD, single-cycle WREN.
- Load byte signed, addr 0x13, SRAM returns 0x80FF_1234 -> RDEN pulse at C+1 with BMASK=1111; o_done at C+5 with rdata=0xFFFF_FF80. Repeating with i_unsigned=1 gives 0x0000_0080.
- Load half, addr 0x11 (misaligned) -> no WREN/RDEN ever; o_done=1 and o_err=1 at C+1. Likewise addr 0x0008_0000 (out of region) and i_size=11.
- i_req held through a load, then a second store request -> second acceptance occurs only in the cycle after the first o_done; exactly one RDEN and one WREN are issued. Async reset asserted in WAIT -> o_done never pulses and o_ready=1 immediately.
- SRAM_TIMEOUT_EN defined, ACK held 0 -> o_done=1 with o_err=1 at C+2+TIMEOUT_CYCLES (±1 cycle by counter convention, fixed by implementation). Without the macro, the bench confirms the block stays in WAIT for 100 cycles.
